// File: rtl/downlink_pkg.sv
// Shared constants, state encoding and configuration field layout for the
// downlink receive path.
package downlink_pkg;

  localparam logic [7:0] PREAMBLE_DEFAULT = 8'b11011101;

  localparam int RES_W     = 1;
  localparam int COMP_W    = 3;
  localparam int REP_W     = 3;
  localparam int PAYLOAD_W = RES_W + COMP_W + REP_W;

  typedef logic [1:0] state_t;
  localparam state_t HUNT    = 2'd0;
  localparam state_t PAYLOAD = 2'd1;
  localparam state_t PENDING = 2'd2;

  // Field order matches arrival order: first received bit lands in the MSB.
  typedef struct packed {
    logic [RES_W-1:0]  resolution;
    logic [COMP_W-1:0] compression;
    logic [REP_W-1:0]  repetition;
  } cfg_t;

  function automatic cfg_t unpack_payload(input logic [PAYLOAD_W-1:0] p);
    return cfg_t'(p);
  endfunction

endpackage

// File: rtl/downlink_gap_timer.sv
// Saturating inter-bit gap counter; timeout pulses once, on the cycle the
// counter reaches saturation without a clearing strobe.
module downlink_gap_timer #(
  parameter int BIT_TIMEOUT = 10000,
  parameter int GAP_W       = 14
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic timeout
);

  localparam logic [GAP_W-1:0] GAP_SAT  = GAP_W'(BIT_TIMEOUT);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(BIT_TIMEOUT - 1);

  logic [GAP_W-1:0] gap_cnt;

  // Reset to saturation so no timeout fires before the first strobe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gap_cnt <= GAP_SAT;
    end else if (clear) begin
      gap_cnt <= '0;
    end else if (gap_cnt != GAP_SAT) begin
      gap_cnt <= gap_cnt + 1'b1;
    end
  end

  assign timeout = !clear && (gap_cnt == GAP_LAST);

endmodule

// File: rtl/downlink_frame_controller.sv
// Downlink frame sequencer: preamble hunt, payload assembly, gap timeout and
// idle-gated commit of the camera configuration.
//
//   state   | meaning
//   HUNT    | sliding search for the preamble
//   PAYLOAD | collecting the 7 payload bits
//   PENDING | payload complete, waiting for cam_idle to commit
module downlink_frame_controller
  import downlink_pkg::*;
#(
  parameter logic [7:0] PREAMBLE    = PREAMBLE_DEFAULT,
  parameter int         BIT_TIMEOUT = 10000,
  parameter int         GAP_W       = 14
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                detected,
  input  logic                downlink_bit,
  input  logic                cam_idle,
  output logic [RES_W-1:0]    cfg_resolution,
  output logic [COMP_W-1:0]   cfg_compression,
  output logic [REP_W-1:0]    cfg_repetition,
  output logic                cfg_update,
  output logic                frame_error,
  output logic                busy
);

  state_t               state;
  logic [7:0]           sync_reg;
  logic [7:0]           sync_next;
  logic [PAYLOAD_W-1:0] payload_reg;
  logic [2:0]           bit_cnt;
  cfg_t                 cfg_q;
  logic                 timeout;

  downlink_gap_timer #(
    .BIT_TIMEOUT(BIT_TIMEOUT),
    .GAP_W      (GAP_W)
  ) u_gap_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (detected),
    .timeout(timeout)
  );

  assign sync_next = {sync_reg[6:0], downlink_bit};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= HUNT;
      sync_reg    <= '0;
      payload_reg <= '0;
      bit_cnt     <= '0;
      cfg_q       <= '0;
      cfg_update  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      cfg_update  <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        HUNT: begin
          if (detected) begin
            if (sync_next == PREAMBLE) begin
              sync_reg <= '0;
              bit_cnt  <= '0;
              state    <= PAYLOAD;
            end else begin
              sync_reg <= sync_next;
            end
          end else if (timeout) begin
            sync_reg <= '0;
          end
        end
        PAYLOAD: begin
          if (detected) begin
            payload_reg <= {payload_reg[PAYLOAD_W-2:0], downlink_bit};
            bit_cnt     <= bit_cnt + 3'd1;
            if (bit_cnt == 3'(PAYLOAD_W - 1)) state <= PENDING;
          end else if (timeout) begin
            frame_error <= 1'b1;
            payload_reg <= '0;
            bit_cnt     <= '0;
            sync_reg    <= '0;
            state       <= HUNT;
          end
        end
        PENDING: begin
          // Strobes and gap timeouts are deliberately ignored while waiting.
          if (cam_idle) begin
            cfg_q      <= unpack_payload(payload_reg);
            cfg_update <= 1'b1;
            state      <= HUNT;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

  assign busy            = (state == PAYLOAD) || (state == PENDING);
  assign cfg_resolution  = cfg_q.resolution;
  assign cfg_compression = cfg_q.compression;
  assign cfg_repetition  = cfg_q.repetition;

endmodule

// File: tb/tb_downlink_frame_controller.sv
// Self-checking bench for downlink_frame_controller: directed frames plus
// randomized traffic, checked each cycle against a queue-based frame model.
module tb_downlink_frame_controller;

  localparam int TIMEOUT = 10000;

  logic       clock = 1'b0;
  logic       reset;
  logic       detected;
  logic       downlink_bit;
  logic       cam_idle;
  logic       cfg_resolution;
  logic [2:0] cfg_compression;
  logic [2:0] cfg_repetition;
  logic       cfg_update;
  logic       frame_error;
  logic       busy;

  downlink_frame_controller dut (
    .clock          (clock),
    .reset          (reset),
    .detected       (detected),
    .downlink_bit   (downlink_bit),
    .cam_idle       (cam_idle),
    .cfg_resolution (cfg_resolution),
    .cfg_compression(cfg_compression),
    .cfg_repetition (cfg_repetition),
    .cfg_update     (cfg_update),
    .frame_error    (frame_error),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int upd_seen = 0;
  int err_seen = 0;

  // Model: bits seen while hunting, payload bits, and phase 0=hunt 1=collect 2=wait.
  bit         hq[$];
  bit         pq[$];
  int         mode;
  int         idle_run;
  logic [7:0] pre = 8'b11011101;
  logic       m_res;
  logic [2:0] m_comp, m_rep;
  logic       m_upd, m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    hq.delete();
    pq.delete();
    mode     = 0;
    idle_run = TIMEOUT;
    m_res    = 1'b0;
    m_comp   = 3'd0;
    m_rep    = 3'd0;
    m_upd    = 1'b0;
    m_err    = 1'b0;
  endtask

  function automatic bit preamble_seen();
    if (hq.size() < 8) return 1'b0;
    for (int i = 0; i < 8; i++)
      if (hq[hq.size() - 8 + i] != pre[7-i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(input bit det, input bit b, input bit idle_in);
    bit tmo;
    tmo = 1'b0;
    if (det) idle_run = 0;
    else if (idle_run < TIMEOUT) begin
      idle_run++;
      if (idle_run == TIMEOUT) tmo = 1'b1;
    end
    m_upd = 1'b0;
    m_err = 1'b0;
    if (mode == 0) begin
      if (det) begin
        hq.push_back(b);
        if (hq.size() > 8) void'(hq.pop_front());
        if (preamble_seen()) begin
          hq.delete();
          pq.delete();
          mode = 1;
        end
      end else if (tmo) hq.delete();
    end else if (mode == 1) begin
      if (det) begin
        pq.push_back(b);
        if (pq.size() == 7) mode = 2;
      end else if (tmo) begin
        m_err = 1'b1;
        pq.delete();
        hq.delete();
        mode = 0;
      end
    end else begin
      if (idle_in) begin
        m_res  = pq[0];
        m_comp = {pq[1], pq[2], pq[3]};
        m_rep  = {pq[4], pq[5], pq[6]};
        m_upd  = 1'b1;
        mode   = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("cfg_resolution", 32'(cfg_resolution), 32'(m_res));
    chk("cfg_compression", 32'(cfg_compression), 32'(m_comp));
    chk("cfg_repetition", 32'(cfg_repetition), 32'(m_rep));
    chk("cfg_update", 32'(cfg_update), 32'(m_upd));
    chk("frame_error", 32'(frame_error), 32'(m_err));
    chk("busy", 32'(busy), 32'(mode != 0));
    if (cfg_update === 1'b1) upd_seen++;
    if (frame_error === 1'b1) err_seen++;
  endtask

  // Inputs change just after a negedge; the next posedge samples them.
  task automatic step(input bit det, input bit b, input bit idle_in);
    detected     = det;
    downlink_bit = b;
    cam_idle     = idle_in;
    model_step(det, b, idle_in);
    @(negedge clock);
    compare_all();
  endtask

  task automatic send_bits(input logic [31:0] v, input int n, input bit idle_in);
    for (int i = n - 1; i >= 0; i--) step(1'b1, v[i], idle_in);
  endtask

  task automatic idle_cycles(input int n, input bit idle_in);
    repeat (n) step(1'b0, 1'b0, idle_in);
  endtask

  task automatic pulse_reset();
    detected = 1'b0;
    reset    = 1'b1;
    #2;
    model_reset();
    compare_all();
    @(negedge clock);
    reset = 1'b0;
    compare_all();
  endtask

  task automatic random_frame();
    logic [6:0] p;
    p = 7'($urandom);
    for (int i = 7; i >= 0; i--) begin
      repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, ($urandom_range(0, 9) < 7));
      step(1'b1, pre[i], ($urandom_range(0, 9) < 7));
    end
    for (int i = 6; i >= 0; i--) begin
      repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, ($urandom_range(0, 9) < 7));
      step(1'b1, p[i], ($urandom_range(0, 9) < 7));
    end
  endtask

  initial begin
    reset        = 1'b1;
    detected     = 1'b0;
    downlink_bit = 1'b0;
    cam_idle     = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    compare_all();

    // Basic frame: payload 1_101_011, commit two edges after the last strobe.
    send_bits(32'hDD, 8, 1'b1);
    send_bits(32'b1101011, 7, 1'b1);
    chk("t1_no_early_update", 32'(cfg_update), 32'd0);
    step(1'b0, 1'b0, 1'b1);
    chk("t1_update", 32'(cfg_update), 32'd1);
    chk("t1_res", 32'(cfg_resolution), 32'd1);
    chk("t1_comp", 32'(cfg_compression), 32'd5);
    chk("t1_rep", 32'(cfg_repetition), 32'd3);
    chk("t1_model_comp", 32'(m_comp), 32'd5);
    idle_cycles(3, 1'b1);
    chk("t1_update_count", 32'(upd_seen), 32'd1);

    // Leading junk then a frame with payload 0_100_110.
    send_bits(32'b0110, 4, 1'b1);
    send_bits(32'hDD, 8, 1'b1);
    send_bits(32'b0100110, 7, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("t2_res", 32'(cfg_resolution), 32'd0);
    chk("t2_comp", 32'(cfg_compression), 32'd4);
    chk("t2_rep", 32'(cfg_repetition), 32'd6);

    // 110111011101 + 010: locks on the first match, payload 1_101_010.
    send_bits(32'hDDD, 12, 1'b1);
    send_bits(32'b010, 3, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("t2b_res", 32'(cfg_resolution), 32'd1);
    chk("t2b_comp", 32'(cfg_compression), 32'd5);
    chk("t2b_rep", 32'(cfg_repetition), 32'd2);
    chk("t2_update_count", 32'(upd_seen), 32'd3);

    // Mid-payload timeout.
    send_bits(32'hDD, 8, 1'b1);
    send_bits(32'b1010, 4, 1'b1);
    idle_cycles(TIMEOUT - 1, 1'b1);
    chk("t3_no_early_error", 32'(err_seen), 32'd0);
    step(1'b0, 1'b0, 1'b1);
    chk("t3_error", 32'(frame_error), 32'd1);
    idle_cycles(2, 1'b1);
    chk("t3_error_count", 32'(err_seen), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_cfg_kept", 32'({cfg_resolution, cfg_compression, cfg_repetition}), 32'b1101010);
    send_bits(32'hDD, 8, 1'b1);
    send_bits(32'b0001111, 7, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("t3_recover", 32'({cfg_resolution, cfg_compression, cfg_repetition}), 32'b0001111);

    // Commit held off by cam_idle=0 with extra strobes.
    send_bits(32'hDD, 8, 1'b0);
    send_bits(32'b1011100, 7, 1'b0);
    for (int i = 0; i < 500; i++) step((i % 7) == 3, 1'($urandom), 1'b0);
    chk("t4_held", 32'(upd_seen), 32'd4);
    step(1'b0, 1'b0, 1'b1);
    chk("t4_commit", 32'({cfg_update, cfg_resolution, cfg_compression, cfg_repetition}), 32'b11011100);

    // Strobe on the would-be timeout cycle keeps the frame alive.
    send_bits(32'hDD, 8, 1'b1);
    send_bits(32'b00, 2, 1'b1);
    idle_cycles(TIMEOUT - 1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    send_bits(32'b0000, 4, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("t5_no_error", 32'(err_seen), 32'd1);
    chk("t5_zero_payload", 32'({cfg_update, cfg_resolution, cfg_compression, cfg_repetition}), 32'b10000000);

    // Reset while PENDING discards the payload.
    send_bits(32'hDD, 8, 1'b0);
    send_bits(32'b1111111, 7, 1'b0);
    idle_cycles(3, 1'b0);
    pulse_reset();
    idle_cycles(5, 1'b1);
    chk("t6_update_count", 32'(upd_seen), 32'd6);
    chk("t6_cfg_zero", 32'({cfg_resolution, cfg_compression, cfg_repetition}), 32'd0);

    // Randomized traffic with occasional long gaps.
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 3))
        0: for (int j = 0; j < $urandom_range(1, 12); j++)
             step(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 9) < 7));
        1: idle_cycles($urandom_range(1, 20), ($urandom_range(0, 1) == 1));
        default: random_frame();
      endcase
      if (it == 30 || it == 60) idle_cycles(TIMEOUT + 1, ($urandom_range(0, 1) == 1));
    end
    idle_cycles(5, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
